axi_error_log: RTL and testbench
================================

Name: axi_error_log

Overview:
- Parametrised successor of the checker's AXI error reporter.
- Instead of one live error snapshot, it queues up to FIFO_DEPTH error records (code + payload) for software to pop.
- Keeps NUM_CTRS 64-bit event counters, readable atomically through an H/L shadow.
- Drives a maskable interrupt. Contains its own AXI4-Lite slave handshake logic; sits between the packet checker and the host register bus.

Parameters:
- ERR_WIDTH, 18, width of error_code (1..32)
- DATA_WORDS, 16, 32-bit payload words per record (1..64)
- FIFO_DEPTH, 8, record slots; power of 2, 2..256
- NUM_CTRS, 4, number of 64-bit event counters (1..28)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- error_valid  in  1  push one record this cycle
- error_code  in  ERR_WIDTH  record code
- error_data  in  32*DATA_WORDS  record payload
- ctr_inc  in  NUM_CTRS  bit i = increment counter i this cycle
- irq  out  1  registered interrupt
- S_AXI_AWADDR in 32; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_AWPROT in 3 (ignored)
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4 (ignored); S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR in 32; S_AXI_ARVALID in 1; S_AXI_ARPROT in 3 (ignored); S_AXI_ARREADY out 1
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1

Behaviour:
- Reset (synchronous, active-high): all AXI outputs 0; irq 0; FIFO empty; counters, dropped count, overflow, irq_en and shadow all 0.
- Register index = ADDR[9:2]; ADDR[31:10] and ADDR[1:0] are ignored.
- Register map:
  - 0 CONFIG (RO): {FIFO_DEPTH-1[7:0], DATA_WORDS[7:0], NUM_CTRS[7:0], 8'h02}
  - 1 STATUS (RO): [15:0] = fifo count, [16] = overflow sticky
  - 2 CONTROL (WO, write-1-to-act): b0 pop head, b1 clear overflow and dropped count, b2 clear all counters; reads return 0
  - 3 IRQ_EN (RW): b0
  - 4 DROPPED (RO): saturating 32-bit count of rejected pushes
  - 5 HEAD_CODE (RO): head error_code, zero-extended; 0 when empty
  - 8+2i CTRi_H (RO): returns counter[63:32] and latches the full 64 bits of counter i into a single shared shadow
  - 9+2i CTRi_L (RO): returns shadow[31:0]
  - 64+k HEAD_DATA k (RO), k < DATA_WORDS: head payload word error_data[(DATA_WORDS-1-k)*32 +: 32] (MSW at k=0); returns 0 when empty
- Any other index: reads return DECERR with RDATA 0; writes return DECERR. Writes to RO registers return SLVERR with no effect.
- AXI write:
  - AWREADY and WREADY both assert for one cycle only when AWVALID and WVALID are both high and BVALID is low.
  - Register effect lands on that cycle.
  - BVALID rises the next cycle and holds until BREADY.
- AXI read:
  - ARREADY is high while RVALID is low.
  - RVALID and RDATA are registered and appear 1 cycle after the AR handshake; they hold stable until RREADY.
  - Single outstanding transaction per channel.
- FIFO:
  - Push is accepted when error_valid and (count < FIFO_DEPTH or a pop occurs in the same cycle).
  - Otherwise the push is dropped: overflow set to 1, DROPPED +1 (saturates at 0xFFFFFFFF).
  - Pop on empty: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
  - If a clear of overflow/dropped coincides with a drop in the same cycle, the drop wins: overflow=1, DROPPED=1.
- Counters:
  - +1 per cycle when the corresponding ctr_inc bit is high; wrap modulo 2^64.
  - Clear coinciding with an increment: clear wins (result 0).
  - Reading CTRi_L without a prior CTRi_H returns stale shadow (documented, not an error).
- irq is registered: irq <= irq_en & ((count != 0) | overflow). One-cycle lag after the state change.

Test Plan:
- Reset, then read index 0 with defaults -> RDATA 0x07100402, RRESP OKAY; index 1 -> 0; BVALID/RVALID low throughout reset.
- Push code 0x2A5A5 with payload words 0..15 = 0x1000+k (k=0 is MSW), then read index 5 -> 0x0002A5A5, index 64 -> 0x1000, index 79 -> 0x100F; write CONTROL=1 -> BRESP OKAY, STATUS count 0.
- Push 10 records with the FIFO empty -> count 8, STATUS=0x00010008, DROPPED=2. Push+pop together while full -> count stays 8, DROPPED stays 2. CONTROL=2 -> STATUS=0x00000008, DROPPED=0.
- Hold ctr_inc[1] high for 0x1_0000_0005 cycles (or force near-wrap) -> read 10 gives 0x00000001, then 11 gives 0x00000005. Pulse CONTROL=4 while ctr_inc high -> counter reads 0 the cycle after.
- IRQ_EN=1 with the FIFO empty -> irq 0. One push -> irq 1 exactly one cycle after count becomes 1. Pop -> irq 0.
- Read index 200 -> DECERR, RDATA 0. Write index 1 -> SLVERR, state unchanged. Hold RREADY low 5 cycles -> RVALID and RDATA stable, ARREADY low until the R handshake.

Source files
------------

// File: rtl/axi_error_log_if.sv
// AXI4-Lite register-bus bundle between the host and the error log.
// The host side drives requests (master); the error log answers them (slave).
interface axi_error_log_if;
   logic [31:0] S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [2:0]  S_AXI_AWPROT;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [31:0] S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi_error_log.sv
// Error-record queue, 64-bit event counters and interrupt behind an AXI4-Lite slave.
// Writes act on the AW/W cycle, read data is registered one cycle after AR; one transaction per channel, B/R hold until ready.
module axi_error_log #(
   parameter int ERR_WIDTH  = 18,
   parameter int DATA_WORDS = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_CTRS   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     error_valid,
   input  logic [ERR_WIDTH-1:0]     error_code,
   input  logic [32*DATA_WORDS-1:0] error_data,
   input  logic [NUM_CTRS-1:0]      ctr_inc,
   output logic                     irq,
   axi_error_log_if.slave           s_axi
);
   localparam int               PTR_W       = $clog2(FIFO_DEPTH);
   localparam int               CNT_W       = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]       RESP_OKAY   = 2'b00;
   localparam logic [1:0]       RESP_SLVERR = 2'b10;
   localparam logic [1:0]       RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [ERR_WIDTH-1:0]     code;
      logic [32*DATA_WORDS-1:0] data;
   } rec_t;

   rec_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [31:0]      dropped_q, dropped_d;
   logic             irq_en_q, irq_en_d, irq_q, irq_d;
   logic [63:0]      ctr_q [NUM_CTRS];
   logic [63:0]      ctr_d [NUM_CTRS];
   logic [63:0]      shadow_q, shadow_d;
   logic             bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d, wr_resp;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rdata_q, rdata_d, rd_word;
   logic [1:0]       rresp_q, rresp_d, rd_resp;
   logic             wr_hs, rd_hs, ctl_wr, push, pop, drop;
   logic [7:0]       wr_idx, rd_idx;
   rec_t             head;
   logic             unused_ok;

   function automatic logic is_mapped(input logic [7:0] idx);
      return (idx <= 8'd5) ||
             (idx >= 8'd8 && idx < 8'(8 + 2*NUM_CTRS)) ||
             (idx >= 8'd64 && idx < 8'(64 + DATA_WORDS));
   endfunction

   assign wr_idx = s_axi.S_AXI_AWADDR[9:2];
   assign rd_idx = s_axi.S_AXI_ARADDR[9:2];
   assign wr_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~reset;
   assign rd_hs  = s_axi.S_AXI_ARVALID & ~rvalid_q & ~reset;
   assign ctl_wr = wr_hs && (wr_idx == 8'd2);
   assign pop    = ctl_wr && s_axi.S_AXI_WDATA[0] && (count_q != '0);
   // A pop in the same cycle frees the slot a full queue would otherwise refuse.
   assign push   = error_valid && ((count_q < DEPTH_C) || pop);
   assign drop   = error_valid && !push;
   assign head   = mem_q[rd_ptr_q];

   assign s_axi.S_AXI_AWREADY = wr_hs;
   assign s_axi.S_AXI_WREADY  = wr_hs;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = ~rvalid_q & ~reset;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign irq                 = irq_q;

   assign unused_ok = ^{s_axi.S_AXI_AWADDR[31:10], s_axi.S_AXI_AWADDR[1:0],
                        s_axi.S_AXI_ARADDR[31:10], s_axi.S_AXI_ARADDR[1:0],
                        s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA[31:3]};

   always_comb begin
      wr_resp = RESP_DECERR;
      if (wr_idx == 8'd2 || wr_idx == 8'd3) wr_resp = RESP_OKAY;
      else if (is_mapped(wr_idx))           wr_resp = RESP_SLVERR;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      dropped_d = dropped_q;
      irq_en_d  = irq_en_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // Clear is applied first so a simultaneous drop leaves overflow=1, dropped=1.
      if (ctl_wr && s_axi.S_AXI_WDATA[1]) begin
         ovf_d     = 1'b0;
         dropped_d = '0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (dropped_d != 32'hFFFF_FFFF) dropped_d = dropped_d + 32'd1;
      end
      for (int i = 0; i < NUM_CTRS; i++) begin
         ctr_d[i] = ctr_q[i] + 64'(ctr_inc[i]);
         if (ctl_wr && s_axi.S_AXI_WDATA[2]) ctr_d[i] = '0;
      end
      if (wr_hs && wr_idx == 8'd3) irq_en_d = s_axi.S_AXI_WDATA[0];
      irq_d = irq_en_q & ((count_q != '0) | ovf_q);
      if (wr_hs) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_resp;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   always_comb begin
      rd_word  = '0;
      rd_resp  = is_mapped(rd_idx) ? RESP_OKAY : RESP_DECERR;
      shadow_d = shadow_q;
      case (rd_idx)
         8'd0:    rd_word = {8'(FIFO_DEPTH - 1), 8'(DATA_WORDS), 8'(NUM_CTRS), 8'h02};
         8'd1:    rd_word = {15'd0, ovf_q, 16'(count_q)};
         8'd3:    rd_word = {31'd0, irq_en_q};
         8'd4:    rd_word = dropped_q;
         8'd5:    rd_word = (count_q != '0) ? 32'(head.code) : 32'd0;
         default: rd_word = '0;
      endcase
      // The high read snapshots the whole counter so the later low read is coherent.
      for (int i = 0; i < NUM_CTRS; i++) begin
         if (rd_idx == 8'(8 + 2*i)) begin
            rd_word = ctr_q[i][63:32];
            if (rd_hs) shadow_d = ctr_q[i];
         end
         if (rd_idx == 8'(9 + 2*i)) rd_word = shadow_q[31:0];
      end
      for (int k = 0; k < DATA_WORDS; k++) begin
         if (rd_idx == 8'(64 + k) && count_q != '0)
            rd_word = head.data[(DATA_WORDS-1-k)*32 +: 32];
      end
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rd_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
         rresp_d  = rd_resp;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{code: error_code, data: error_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         dropped_q <= '0;
         irq_en_q  <= 1'b0;
         irq_q     <= 1'b0;
         shadow_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         for (int i = 0; i < NUM_CTRS; i++) ctr_q[i] <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         dropped_q <= dropped_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_d;
         shadow_q  <= shadow_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         for (int i = 0; i < NUM_CTRS; i++) ctr_q[i] <= ctr_d[i];
      end
   end
endmodule

// File: tb/tb_axi_error_log.sv
// Directed plus randomized bench for axi_error_log against a queue-based reference model.
module tb_axi_error_log;
   localparam int EW = 18;
   localparam int DW = 16;
   localparam int FD = 8;
   localparam int NC = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              error_valid;
   logic [EW-1:0]     error_code;
   logic [32*DW-1:0]  error_data;
   logic [NC-1:0]     ctr_inc;
   logic              irq;

   axi_error_log_if bus();

   axi_error_log #(.ERR_WIDTH(EW), .DATA_WORDS(DW), .FIFO_DEPTH(FD), .NUM_CTRS(NC)) dut (
      .clk(clk), .reset(reset), .error_valid(error_valid), .error_code(error_code),
      .error_data(error_data), .ctr_inc(ctr_inc), .irq(irq), .s_axi(bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [EW-1:0]    m_code [$];
   logic [32*DW-1:0] m_data [$];
   logic             m_ovf = 1'b0;
   logic [31:0]      m_dropped = '0;
   logic [63:0]      m_ctr [NC];
   logic [63:0]      m_shadow = '0;
   logic             m_irq_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32*DW-1:0] rand_data();
      logic [32*DW-1:0] d;
      for (int w = 0; w < DW; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic m_push(input logic [EW-1:0] c, input logic [32*DW-1:0] d);
      if (m_code.size() < FD) begin
         m_code.push_back(c);
         m_data.push_back(d);
      end else begin
         m_ovf = 1'b1;
         if (m_dropped != 32'hFFFF_FFFF) m_dropped = m_dropped + 1;
      end
   endtask

   task automatic m_write(input logic [7:0] idx, input logic [31:0] d, input logic [NC-1:0] inc,
                          input logic pv, input logic [EW-1:0] pc, input logic [32*DW-1:0] pd,
                          output logic [1:0] resp);
      for (int i = 0; i < NC; i++) if (inc[i]) m_ctr[i] = m_ctr[i] + 1;
      if (idx == 2 || idx == 3) resp = 2'b00;
      else if (idx <= 5 || (idx >= 8 && idx < 8 + 2*NC) || (idx >= 64 && idx < 64 + DW)) resp = 2'b10;
      else resp = 2'b11;
      if (idx == 2) begin
         if (d[0] && m_code.size() > 0) begin
            void'(m_code.pop_front());
            void'(m_data.pop_front());
         end
         if (d[1]) begin m_ovf = 1'b0; m_dropped = '0; end
         if (d[2]) for (int i = 0; i < NC; i++) m_ctr[i] = '0;
      end
      if (idx == 3) m_irq_en = d[0];
      if (pv) m_push(pc, pd);
   endtask

   task automatic m_read(input logic [7:0] idx, output logic [31:0] d, output logic [1:0] resp);
      logic [32*DW-1:0] h;
      int n;
      n = m_code.size();
      d = '0;
      resp = 2'b00;
      if (idx == 0) d = 32'h0710_0402;
      else if (idx == 1) d = {15'd0, m_ovf, 16'(n)};
      else if (idx == 2) d = '0;
      else if (idx == 3) d = {31'd0, m_irq_en};
      else if (idx == 4) d = m_dropped;
      else if (idx == 5) d = (n > 0) ? 32'(m_code[0]) : 32'd0;
      else if (idx >= 8 && idx < 8 + 2*NC) begin
         if (idx[0] == 1'b0) begin
            m_shadow = m_ctr[(idx - 8) / 2];
            d = m_shadow[63:32];
         end else begin
            d = m_shadow[31:0];
         end
      end else if (idx >= 64 && idx < 64 + DW) begin
         if (n > 0) begin
            h = m_data[0];
            d = h[(DW - 1 - (idx - 64))*32 +: 32];
         end
      end else resp = 2'b11;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [NC-1:0] inc,
                            input logic pv, input logic [EW-1:0] pc, input logic [32*DW-1:0] pd,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      bus.S_AXI_AWADDR = addr;  bus.S_AXI_AWPROT = 3'($urandom);  bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA  = data;  bus.S_AXI_WSTRB  = 4'($urandom);  bus.S_AXI_WVALID  = 1'b1;
      ctr_inc = inc;  error_valid = pv;  error_code = pc;  error_data = pd;
      #1;
      n = 0;
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 50) begin @(negedge clk); #1; n++; end
      check("aw_w_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;  bus.S_AXI_WVALID = 1'b0;  ctr_inc = '0;  error_valid = 1'b0;
      check("bvalid_rise", bus.S_AXI_BVALID, 1'b1);
      resp = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int n;
      @(negedge clk);
      bus.S_AXI_ARADDR = addr;  bus.S_AXI_ARPROT = 3'($urandom);  bus.S_AXI_ARVALID = 1'b1;
      #1;
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); #1; n++; end
      check("arready", bus.S_AXI_ARREADY, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      check("rvalid_1cyc", bus.S_AXI_RVALID, 1'b1);
      data = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check("r_hold", {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, {1'b1, resp, data});
         check("arready_low", bus.S_AXI_ARREADY, 1'b0);
      end
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      if (hold > 0) check("rvalid_drop", bus.S_AXI_RVALID, 1'b0);
   endtask

   function automatic logic [31:0] mk_addr(input logic [7:0] idx);
      return {22'($urandom), idx, 2'($urandom)};
   endfunction

   task automatic do_write(input logic [7:0] idx, input logic [31:0] d, input logic [NC-1:0] inc,
                           input logic pv, input logic [EW-1:0] pc, input logic [32*DW-1:0] pd);
      logic [1:0] r, er;
      axi_write(mk_addr(idx), d, inc, pv, pc, pd, r);
      m_write(idx, d, inc, pv, pc, pd, er);
      check($sformatf("bresp_idx%0d", idx), r, er);
   endtask

   task automatic do_read(input logic [7:0] idx, input int hold, output logic [31:0] d);
      logic [31:0] ed;
      logic [1:0]  r, er;
      axi_read(mk_addr(idx), hold, d, r);
      m_read(idx, ed, er);
      check($sformatf("rdata_idx%0d", idx), d, ed);
      check($sformatf("rresp_idx%0d", idx), r, er);
   endtask

   task automatic push_one(input logic [EW-1:0] c, input logic [32*DW-1:0] d);
      @(negedge clk);
      error_valid = 1'b1;  error_code = c;  error_data = d;
      @(negedge clk);
      error_valid = 1'b0;
      m_push(c, d);
   endtask

   task automatic ctr_burst(input logic [NC-1:0] bits, input int len);
      @(negedge clk);
      ctr_inc = bits;
      repeat (len) @(negedge clk);
      ctr_inc = '0;
      for (int i = 0; i < NC; i++) if (bits[i]) m_ctr[i] = m_ctr[i] + 64'(len);
   endtask

   initial begin
      logic [31:0]      rd;
      logic [32*DW-1:0] pd;
      int               op;

      for (int i = 0; i < NC; i++) m_ctr[i] = '0;
      reset = 1'b1;  error_valid = 1'b0;  error_code = '0;  error_data = '0;  ctr_inc = '0;
      bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWVALID = 1'b1;  bus.S_AXI_AWPROT = '0;
      bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB   = '0;    bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARVALID = 1'b1;  bus.S_AXI_ARPROT = '0;
      bus.S_AXI_RREADY = 1'b0;

      // Outputs stay quiet in reset even with every request asserted.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_outs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                              bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA, irq}, '0);
      end
      bus.S_AXI_AWVALID = 1'b0;  bus.S_AXI_WVALID = 1'b0;  bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      do_read(8'd0, 0, rd);  check("config", rd, 32'h0710_0402);
      do_read(8'd1, 0, rd);  check("status_reset", rd, 32'h0);

      for (int k = 0; k < DW; k++) pd[(DW-1-k)*32 +: 32] = 32'h1000 + k;
      push_one(18'h2A5A5, pd);
      do_read(8'd5, 0, rd);   check("head_code", rd, 32'h0002_A5A5);
      do_read(8'd64, 0, rd);  check("head_w0", rd, 32'h1000);
      do_read(8'd79, 0, rd);  check("head_w15", rd, 32'h100F);
      do_write(8'd2, 32'h1, '0, 1'b0, '0, '0);
      do_read(8'd1, 0, rd);   check("status_popped", rd, 32'h0);

      for (int p = 0; p < 10; p++) push_one(EW'($urandom), rand_data());
      do_read(8'd1, 0, rd);   check("status_full", rd, 32'h0001_0008);
      do_read(8'd4, 0, rd);   check("dropped2", rd, 32'd2);
      do_write(8'd2, 32'h1, '0, 1'b1, EW'($urandom), rand_data());
      do_read(8'd1, 0, rd);   check("status_pushpop", rd, 32'h0001_0008);
      do_read(8'd4, 0, rd);   check("dropped_pushpop", rd, 32'd2);
      do_read(8'd5, 0, rd);
      do_write(8'd2, 32'h2, '0, 1'b0, '0, '0);
      do_read(8'd1, 0, rd);   check("status_clr", rd, 32'h0000_0008);
      do_read(8'd4, 0, rd);   check("dropped_clr", rd, 32'd0);
      do_write(8'd2, 32'h2, '0, 1'b1, EW'($urandom), rand_data());
      do_read(8'd1, 0, rd);   check("status_clr_drop", rd, 32'h0001_0008);
      do_read(8'd4, 0, rd);   check("dropped_clr_drop", rd, 32'd1);
      do_write(8'd2, 32'h2, '0, 1'b0, '0, '0);

      ctr_burst(4'b0010, 300);
      do_read(8'd10, 0, rd);  check("ctr1_hi", rd, 32'd0);
      do_read(8'd11, 0, rd);  check("ctr1_lo", rd, 32'd300);
      ctr_burst(4'b1111, 7);
      do_read(8'd9, 0, rd);   check("ctr0_lo_stale", rd, 32'd300);
      do_read(8'd8, 0, rd);
      do_read(8'd9, 0, rd);   check("ctr0_lo", rd, 32'd7);
      do_write(8'd2, 32'h4, 4'b1111, 1'b0, '0, '0);
      do_read(8'd10, 0, rd);
      do_read(8'd11, 0, rd);  check("ctr1_cleared", rd, 32'd0);
      do_read(8'd14, 0, rd);
      do_read(8'd15, 0, rd);  check("ctr3_cleared", rd, 32'd0);

      for (int p = 0; p < FD; p++) do_write(8'd2, 32'h1, '0, 1'b0, '0, '0);
      do_write(8'd3, 32'h1, '0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      check("irq_empty", irq, 1'b0);
      @(negedge clk);
      error_valid = 1'b1;  error_code = 18'h155;  error_data = rand_data();
      m_push(error_code, error_data);
      @(negedge clk);
      error_valid = 1'b0;
      check("irq_lag", irq, 1'b0);
      @(negedge clk);
      check("irq_set", irq, 1'b1);
      do_write(8'd2, 32'h1, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("irq_clear", irq, 1'b0);
      do_read(8'd3, 0, rd);

      do_read(8'd200, 0, rd);  check("decerr_rdata", rd, 32'd0);
      do_read(8'd6, 0, rd);
      push_one(18'h3_0F0F, rand_data());
      do_write(8'd1, 32'hFFFF_FFFF, '0, 1'b0, '0, '0);
      do_write(8'd5, 32'hFFFF_FFFF, '0, 1'b0, '0, '0);
      do_write(8'd200, 32'h7, '0, 1'b0, '0, '0);
      do_read(8'd1, 0, rd);    check("status_ro_write", rd, 32'h1);
      do_read(8'd5, 5, rd);    check("hold_head", rd, 32'h0003_0F0F);

      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 6);
         case (op)
            0: for (int p = 0; p < $urandom_range(1, 4); p++) push_one(EW'($urandom), rand_data());
            1: do_write(8'd2, 32'($urandom_range(0, 7)), NC'($urandom), 1'($urandom), EW'($urandom), rand_data());
            2: ctr_burst(NC'($urandom), $urandom_range(1, 40));
            3: do_write(8'd3, 32'($urandom), '0, 1'b0, '0, '0);
            4: do_read(8'($urandom_range(0, 127)), $urandom_range(0, 2), rd);
            5: do_read(8'(8 + 2*$urandom_range(0, NC-1)), 0, rd);
            default: do_read(8'($urandom_range(0, 255)), 0, rd);
         endcase
         do_read(8'd1, 0, rd);
         if (it % 4 == 0) begin
            do_read(8'd9 + 8'(2*$urandom_range(0, NC-1)), 0, rd);
            repeat (2) @(negedge clk);
            check("irq_model", irq, m_irq_en & ((m_code.size() != 0) | m_ovf));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
